// File: rtl/fft8_pkg.sv
// fft8_pkg: shared types and constants for the 8-point FFT frame sequencer.
//   state_e   : sequencer FSM states
//   FFT_N     : samples / bins per frame
//   FFT_PAIRS : X1/X2 output pairs produced by the processor per frame
//   bin_t     : 3-bit bin / buffer index
//   emit_slot : output buffer slot presented on a given EMIT beat
// Build option: FFT8_SEQ_NATURAL_ORDER_EN selects natural bin order on output;
// when undefined, bins leave in capture order 0,4,1,5,2,6,3,7.
package fft8_pkg;

  localparam int FFT_N     = 8;
  localparam int FFT_PAIRS = 4;

  typedef logic [2:0] bin_t;

  typedef enum logic [2:0] {
    FILL,
    FEED,
    WAIT,
    CAPTURE,
    EMIT
  } state_e;

  function automatic bin_t emit_slot(input bin_t beat);
`ifdef FFT8_SEQ_NATURAL_ORDER_EN
    return beat;
`else
    // Capture order interleaves X1 (slots 0..3) with X2 (slots 4..7).
    return {beat[0], beat[2:1]};
`endif
  endfunction

endpackage

// File: rtl/fft8_seq_buf.sv
// fft8_seq_buf: 8-entry x 2W register file, combinational read, no reset on
// the data array. Port B is a second write port, active only when DUAL_WR!=0;
// if both ports hit the same address in one cycle, port B wins.
//   clk_i          : clock
//   we_a_i/wa_a_i/wd_a_i : write port A (enable, address, data)
//   we_b_i/wa_b_i/wd_b_i : write port B (enable, address, data)
//   ra_i / rd_o    : read address / read data
module fft8_seq_buf
  import fft8_pkg::*;
#(
  parameter int W       = 16,
  parameter int DUAL_WR = 0
) (
  input  logic           clk_i,
  input  logic           we_a_i,
  input  bin_t           wa_a_i,
  input  logic [2*W-1:0] wd_a_i,
  input  logic           we_b_i,
  input  bin_t           wa_b_i,
  input  logic [2*W-1:0] wd_b_i,
  input  bin_t           ra_i,
  output logic [2*W-1:0] rd_o
);

  logic [2*W-1:0] mem_q [FFT_N];

  always_ff @(posedge clk_i) begin
    if (we_a_i) mem_q[wa_a_i] <= wd_a_i;
    if ((DUAL_WR != 0) && we_b_i) mem_q[wa_b_i] <= wd_b_i;
  end

  assign rd_o = mem_q[ra_i];

endmodule

// File: rtl/fft8_sequencer.sv
// fft8_sequencer: buffers one 8-sample frame, streams it into the FFT
// processor for 8 contiguous cycles, captures the 4 X1/X2 pairs after LAT
// edges and re-emits the 8 bins on a valid/ready stream.
//   c, rst_n            : clock, async active-low reset
//   flush               : synchronous frame abort
//   s_valid/s_ready, s_re/s_im          : input sample stream
//   p_xr/p_xi/p_en      : processor drive
//   p_X1r/p_X1i/p_X2r/p_X2i             : processor result pair
//   m_valid/m_ready, m_re/m_im, m_bin, m_last : output bin stream
//   busy                : high outside FILL
// Build option: FFT8_SEQ_NATURAL_ORDER_EN (see fft8_pkg::emit_slot).
//
// state   | meaning
// --------+-------------------------------------------------------------
// FILL    | accept 8 samples into the input buffer (cnt = write index)
// FEED    | drive processor with entry cnt, p_en high, 8 cycles
// WAIT    | LAT-1 idle cycles for processor latency (skipped for LAT=1)
// CAPTURE | store pair cnt into output slots cnt and cnt+4, 4 cycles
// EMIT    | present beat cnt, advance on m_valid && m_ready
module fft8_sequencer
  import fft8_pkg::*;
#(
  parameter int W   = 16,
  parameter int LAT = 4
) (
  input  logic         c,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_re,
  input  logic [W-1:0] s_im,
  output logic [W-1:0] p_xr,
  output logic [W-1:0] p_xi,
  output logic         p_en,
  input  logic [W-1:0] p_X1r,
  input  logic [W-1:0] p_X1i,
  input  logic [W-1:0] p_X2r,
  input  logic [W-1:0] p_X2i,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_re,
  output logic [W-1:0] m_im,
  output bin_t         m_bin,
  output logic         m_last,
  output logic         busy
);

  localparam int WAIT_W = (LAT > 2) ? $clog2(LAT - 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = (LAT > 1) ? WAIT_W'(LAT - 2) : '0;

  state_e              state_q, state_d;
  bin_t                cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic                s_ready_q, s_ready_d;
  logic                p_en_q, p_en_d;
  logic [W-1:0]        p_xr_q, p_xr_d, p_xi_q, p_xi_d;
  logic                m_valid_q, m_valid_d;
  logic [W-1:0]        m_re_q, m_re_d, m_im_q, m_im_d;
  bin_t                m_bin_q, m_bin_d;
  logic                m_last_q, m_last_d;

  logic                in_we, out_we;
  logic [2*W-1:0]      in_rd, out_rd;
  bin_t                out_ra;

  // Next-state and counters
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    if (flush) begin
      state_d = FILL;
      cnt_d   = '0;
      wait_d  = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (s_valid && s_ready_q) begin
            if (cnt_q == bin_t'(FFT_N - 1)) begin
              state_d = FEED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        FEED: begin
          if (cnt_q == bin_t'(FFT_N - 1)) begin
            cnt_d = '0;
            if (LAT > 1) begin
              state_d = WAIT;
              wait_d  = WAIT_LOAD;
            end else begin
              state_d = CAPTURE;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        WAIT: begin
          if (wait_q == '0) state_d = CAPTURE;
          else              wait_d  = wait_q - WAIT_W'(1);
        end
        CAPTURE: begin
          if (cnt_q == bin_t'(FFT_PAIRS - 1)) begin
            state_d = EMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        EMIT: begin
          if (m_valid_q && m_ready) begin
            if (cnt_q == bin_t'(FFT_N - 1)) begin
              state_d = FILL;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        default: begin
          state_d = FILL;
          cnt_d   = '0;
          wait_d  = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state, so each one is valid in the
  // same cycle as the state it belongs to. Buffers are read at the next count.
  assign out_ra = emit_slot(cnt_d);

  always_comb begin
    s_ready_d = (state_d == FILL);
    p_en_d    = 1'b0;
    p_xr_d    = '0;
    p_xi_d    = '0;
    m_valid_d = 1'b0;
    m_re_d    = '0;
    m_im_d    = '0;
    m_bin_d   = '0;
    m_last_d  = 1'b0;
    if (state_d == FEED) begin
      p_en_d = 1'b1;
      p_xr_d = in_rd[2*W-1:W];
      p_xi_d = in_rd[W-1:0];
    end
    if (state_d == EMIT) begin
      m_valid_d = 1'b1;
      m_re_d    = out_rd[2*W-1:W];
      m_im_d    = out_rd[W-1:0];
      m_bin_d   = out_ra;
      m_last_d  = (cnt_d == bin_t'(FFT_N - 1));
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      wait_q    <= '0;
      s_ready_q <= 1'b0;
      p_en_q    <= 1'b0;
      p_xr_q    <= '0;
      p_xi_q    <= '0;
      m_valid_q <= 1'b0;
      m_re_q    <= '0;
      m_im_q    <= '0;
      m_bin_q   <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      s_ready_q <= s_ready_d;
      p_en_q    <= p_en_d;
      p_xr_q    <= p_xr_d;
      p_xi_q    <= p_xi_d;
      m_valid_q <= m_valid_d;
      m_re_q    <= m_re_d;
      m_im_q    <= m_im_d;
      m_bin_q   <= m_bin_d;
      m_last_q  <= m_last_d;
    end
  end

  assign in_we  = (state_q == FILL) && s_valid && s_ready_q && !flush;
  assign out_we = (state_q == CAPTURE) && !flush;

  fft8_seq_buf #(.W(W), .DUAL_WR(0)) u_in_buf (
    .clk_i  (c),
    .we_a_i (in_we),
    .wa_a_i (cnt_q),
    .wd_a_i ({s_re, s_im}),
    .we_b_i (1'b0),
    .wa_b_i ('0),
    .wd_b_i ('0),
    .ra_i   (cnt_d),
    .rd_o   (in_rd)
  );

  // Pair k lands in slot k (X1) and slot k+4 (X2) in the same cycle.
  fft8_seq_buf #(.W(W), .DUAL_WR(1)) u_out_buf (
    .clk_i  (c),
    .we_a_i (out_we),
    .wa_a_i ({1'b0, cnt_q[1:0]}),
    .wd_a_i ({p_X1r, p_X1i}),
    .we_b_i (out_we),
    .wa_b_i ({1'b1, cnt_q[1:0]}),
    .wd_b_i ({p_X2r, p_X2i}),
    .ra_i   (out_ra),
    .rd_o   (out_rd)
  );

  assign s_ready = s_ready_q;
  assign p_en    = p_en_q;
  assign p_xr    = p_xr_q;
  assign p_xi    = p_xi_q;
  assign m_valid = m_valid_q;
  assign m_re    = m_re_q;
  assign m_im    = m_im_q;
  assign m_bin   = m_bin_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q != FILL);

endmodule

// File: tb/tb_fft8_sequencer.sv
// tb_fft8_sequencer: scoreboard bench for fft8_sequencer with a behavioural
// processor model returning pair k = (10k, 100+k) / (10k+40, 104+k).
module tb_fft8_sequencer;

  localparam int W   = 16;
  localparam int LAT = 4;

  typedef struct packed {
    logic [2:0]   bin;
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         last;
  } beat_t;

  logic         c = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_re = '0, s_im = '0;
  logic [W-1:0] p_xr, p_xi;
  logic         p_en;
  logic [W-1:0] p_X1r = '0, p_X1i = '0, p_X2r = '0, p_X2i = '0;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [W-1:0] m_re, m_im;
  logic [2:0]   m_bin;
  logic         m_last;
  logic         busy;

  fft8_sequencer #(.W(W), .LAT(LAT)) dut (
    .c       (c),
    .rst_n   (rst_n),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_re    (s_re),
    .s_im    (s_im),
    .p_xr    (p_xr),
    .p_xi    (p_xi),
    .p_en    (p_en),
    .p_X1r   (p_X1r),
    .p_X1i   (p_X1i),
    .p_X2r   (p_X2r),
    .p_X2i   (p_X2i),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_re    (m_re),
    .m_im    (m_im),
    .m_bin   (m_bin),
    .m_last  (m_last),
    .busy    (busy)
  );

  always #5 c = ~c;

  int n_cmp = 0;
  int n_err = 0;

  logic [2*W-1:0] src_q[$];
  logic [2*W-1:0] feed_q[$];
  beat_t          em_q[$];

  int  frame_pos = 0;
  int  frame_beats = 0;
  bit  toggle_mode = 1'b0;
  bit  valid_phase = 1'b0;
  bit  expect_short = 1'b0;
  int  cyc = 0;
  int  pen_run = 0;
  int  last_rise = 0;
  int  pen_rise_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic bound(input string nm, input bit ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: timed out, got not-reached, expected reached", nm);
    end
  endtask

  function automatic logic [2:0] exp_bin(input int j);
`ifdef FFT8_SEQ_NATURAL_ORDER_EN
    return 3'(j);
`else
    int ord [8];
    ord = '{0, 4, 1, 5, 2, 6, 3, 7};
    return 3'(ord[j]);
`endif
  endfunction

  function automatic beat_t make_beat(input int j);
    beat_t b;
    b.bin  = exp_bin(j);
    b.re   = W'(10 * int'(b.bin));
    b.im   = W'(100 + int'(b.bin));
    b.last = (j == 7);
    return b;
  endfunction

  task automatic tick();
    @(posedge c);
    #2;
  endtask

  function automatic bit idle();
    return (src_q.size() == 0) && (em_q.size() == 0) && (feed_q.size() == 0) && !busy;
  endfunction

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    while (!idle() && n < budget) begin
      tick();
      n++;
    end
    bound(nm, idle());
  endtask

  // Sample source: samples accepted on an edge move to the feed scoreboard;
  // each completed frame pushes its 8 expected output beats.
  initial begin
    bit hs;
    forever begin
      @(negedge c);
      hs = rst_n && !flush && s_valid && s_ready;
      @(posedge c);
      #1;
      if (hs && src_q.size() > 0) begin
        feed_q.push_back(src_q.pop_front());
        frame_pos++;
        if (frame_pos == 8) begin
          frame_pos = 0;
          for (int j = 0; j < 8; j++) em_q.push_back(make_beat(j));
        end
      end
      valid_phase = !valid_phase;
      if (src_q.size() > 0 && (!toggle_mode || valid_phase)) begin
        s_valid = 1'b1;
        {s_re, s_im} = src_q[0];
      end else begin
        s_valid = 1'b0;
        s_re = '0;
        s_im = '0;
      end
    end
  end

  // Processor model: pair k is valid only in cycle t0+7+LAT+k.
  initial begin
    int en_run, post, k;
    bit armed;
    en_run = 0; post = 0; armed = 1'b0;
    forever begin
      @(posedge c);
      #1;
      if (!rst_n) begin
        en_run = 0;
        armed = 1'b0;
      end else if (p_en) begin
        en_run++;
        armed = 1'b0;
      end else begin
        if (en_run == 8) begin
          armed = 1'b1;
          post = 0;
        end else if (armed) begin
          post++;
        end
        en_run = 0;
      end
      if (armed && post >= LAT - 1 && post <= LAT + 2) begin
        k = post - (LAT - 1);
        p_X1r = W'(10 * k);
        p_X1i = W'(100 + k);
        p_X2r = W'(10 * k + 40);
        p_X2i = W'(104 + k);
      end else begin
        p_X1r = W'(16'hDEAD);
        p_X1i = W'(16'hDEAD);
        p_X2r = W'(16'hDEAD);
        p_X2i = W'(16'hDEAD);
      end
      if (armed && post > LAT + 2) armed = 1'b0;
    end
  end

  // p_en run length and m_valid latency from first p_en.
  initial begin
    bit pen_prev, mv_prev;
    pen_prev = 1'b0; mv_prev = 1'b0;
    forever begin
      @(posedge c);
      cyc++;
      #1;
      if (p_en) begin
        if (!pen_prev) begin
          pen_rise_q.push_back(cyc);
          last_rise = cyc;
        end
        pen_run++;
      end else begin
        if (pen_prev && !expect_short) chk("pen_run", pen_run, 8);
        pen_run = 0;
      end
      if (m_valid && !mv_prev) chk("mvalid_lat", cyc - last_rise, 11 + LAT);
      pen_prev = p_en;
      mv_prev = m_valid;
    end
  end

  // Feed monitor
  initial begin
    logic [2*W-1:0] e;
    forever begin
      @(negedge c);
      if (rst_n && p_en) begin
        if (feed_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL feed_extra: got p_xr %0d, expected no p_en", p_xr);
        end else begin
          e = feed_q.pop_front();
          chk("feed_re", p_xr, e[2*W-1:W]);
          chk("feed_im", p_xi, e[W-1:0]);
        end
      end
    end
  end

  // Emit monitor
  initial begin
    beat_t e;
    forever begin
      @(negedge c);
      if (rst_n && !flush && m_valid && m_ready) begin
        if (em_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL emit_extra: got bin %0d, expected no beat", m_bin);
        end else begin
          e = em_q.pop_front();
          chk("emit_bin", m_bin, e.bin);
          chk("emit_re", m_re, e.re);
          chk("emit_im", m_im, e.im);
          chk("emit_last", m_last, e.last);
          frame_beats = e.last ? 0 : frame_beats + 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r0;
    repeat (3) @(posedge c);
    @(negedge c);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_p_en", p_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_p_xr", p_xr, 0);
    chk("rst_p_xi", p_xi, 0);
    chk("rst_m_re", m_re, 0);
    chk("rst_m_im", m_im, 0);
    chk("rst_m_bin", m_bin, 0);
    #2 rst_n = 1'b1;
    #1 chk("s_ready_before_edge", s_ready, 0);
    tick();
    chk("s_ready_after_edge", s_ready, 1);

    // Basic frame: re=0..7, im=0
    for (int i = 0; i < 8; i++) src_q.push_back({W'(i), W'(0)});
    wait_idle("frame_basic", 200);

    // Input stalls
    toggle_mode = 1'b1;
    for (int i = 0; i < 8; i++) src_q.push_back({W'(i), W'(7 - i)});
    wait_idle("frame_stall_in", 200);
    toggle_mode = 1'b0;

    // Output backpressure at beat 2
    for (int i = 0; i < 8; i++) src_q.push_back({W'(100 + i), W'(i)});
    n = 0;
    while (!(m_valid && frame_beats == 2) && n < 200) begin tick(); n++; end
    bound("reach_beat2", m_valid && frame_beats == 2);
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_bin", m_bin, exp_bin(2));
      chk("hold_re", m_re, 10 * int'(exp_bin(2)));
      tick();
    end
    m_ready = 1'b1;
    wait_idle("frame_backpressure", 200);

    // Flush during FEED k=3
    for (int i = 0; i < 8; i++) src_q.push_back({W'(200 + i), W'(i)});
    n = 0;
    while (!(p_en && pen_run == 4) && n < 200) begin tick(); n++; end
    bound("reach_feed_k3", p_en && pen_run == 4);
    expect_short = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_p_en", p_en, 0);
    chk("flush_s_ready", s_ready, 1);
    chk("flush_busy", busy, 0);
    feed_q.delete();
    em_q.delete();
    frame_pos = 0;
    expect_short = 1'b0;
    for (int i = 0; i < 8; i++) src_q.push_back({W'(30 + i), W'(5 * i)});
    wait_idle("frame_after_flush", 200);

    // Reset pulse during EMIT beat 5
    for (int i = 0; i < 8; i++) src_q.push_back({W'(i), W'(i)});
    n = 0;
    while (!(m_valid && frame_beats == 5) && n < 200) begin tick(); n++; end
    bound("reach_beat5", m_valid && frame_beats == 5);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_m_last", m_last, 0);
    chk("arst_m_re", m_re, 0);
    chk("arst_m_bin", m_bin, 0);
    chk("arst_busy", busy, 0);
    chk("arst_s_ready", s_ready, 0);
    em_q.delete();
    feed_q.delete();
    frame_beats = 0;
    frame_pos = 0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) src_q.push_back({W'(60 + i), W'(9 - i)});
    wait_idle("frame_after_reset", 200);

    // Back-to-back frames, input pre-queued
    r0 = pen_rise_q.size();
    for (int i = 0; i < 16; i++) src_q.push_back({W'(50 + i), W'(i)});
    wait_idle("frames_b2b", 400);
    chk("b2b_frames", pen_rise_q.size() - r0, 2);
    if (pen_rise_q.size() >= r0 + 2)
      chk("frame_period", pen_rise_q[r0 + 1] - pen_rise_q[r0], 27 + LAT);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft8_sequencer.md
# fft8_sequencer

Frame sequencer for the 8-point FFT `processor`. It accepts complex samples over a valid/ready stream and buffers one 8-sample frame. It then drives the processor's `xr`/`xi`/`en` inputs for exactly 8 contiguous cycles and captures the four `X1`/`X2` output pairs after a fixed latency. Finally it re-emits the 8 bins over a valid/ready output stream. It sits between the sample source and the downstream consumer, with `processor` as its only datapath.

## Interface
Parameters:
- `W`, 16 — sample and bin width (two's complement)
- `LAT`, 4 — processor latency: edges from the end of the last `p_en`-high cycle to the first valid output pair

Ports:
- `c` in 1 — clock, rising edge
- `rst_n` in 1 — reset, asynchronous, active-low
- `flush` in 1 — synchronous abort; discards the current frame
- `s_valid` in 1 / `s_ready` out 1 — input sample handshake
- `s_re`, `s_im` in W — input sample
- `p_xr`, `p_xi` out W — to `processor.xr`/`xi`
- `p_en` out 1 — to `processor.en`
- `p_X1r`, `p_X1i`, `p_X2r`, `p_X2i` in W — from `processor`
- `m_valid` out 1 / `m_ready` in 1 — output bin handshake
- `m_re`, `m_im` out W — output bin value
- `m_bin` out 3 — bin index of current beat
- `m_last` out 1 — high on 8th beat of a frame
- `busy` out 1 — high in any state except FILL

## Operation
- States: FILL → FEED → WAIT → CAPTURE → EMIT → FILL.
- FILL:
  - `s_ready`=1; each `s_valid&&s_ready` writes input buffer entry `wr_idx` (0..7), then increments.
  - Acceptance of entry 7 → FEED next cycle.
- FEED: 8 cycles, counter k=0..7; registered `p_en`=1, `p_xr`/`p_xi` = entry k. After k=7 → WAIT.
- WAIT: LAT-1 cycles; `p_en`=0, `p_xr`/`p_xi`=0. For LAT=1, WAIT is skipped.
- CAPTURE: 4 cycles, k=0..3.
  - Processor contract: pair k carries `X1`=bin k, `X2`=bin k+4.
  - Both are stored into output buffer slots k and k+4.
- EMIT:
  - `m_valid`=1; beat j presents the selected slot (see Configuration).
  - Advance only on `m_valid&&m_ready`. `m_last`=1 on j=7.
  - Acceptance of beat 7 → FILL.
- Outputs are held stable while `m_valid&&!m_ready`.
- Widths: samples and bins pass through unmodified at W bits; no scaling or saturation.
- No overlap: input is not accepted during FEED..EMIT (`s_ready`=0).

## Timing
- Reset values: state FILL, all counters 0; `s_ready`, `p_en`, `m_valid`, `m_last`, `busy` = 0; `p_xr`, `p_xi`, `m_re`, `m_im`, `m_bin` = 0.
- `s_ready` rises on the first edge after `rst_n` deasserts.
- Let t0 be the first cycle `p_en`=1.
  - `p_en`=1 during t0..t0+7 exactly, with no gaps.
  - Pair k is sampled on edge t0+8+LAT-1+k, i.e. the LAT-th edge after cycle t0+7 ends, plus k.
- `m_valid` rises the cycle after CAPTURE k=3.
- Minimum frame period with `m_ready`=1: 8 + 8 + (LAT-1) + 4 + 8 = 27+LAT cycles.
- `flush`:
  - Takes priority over all handshakes; next cycle is FILL with counters cleared.
  - `p_en`, `m_valid`, `m_last` drop to 0 and `s_ready` returns to 1.
  - A beat presented in the same cycle as `flush` is not considered transferred.
- `rst_n` asserted mid-frame: immediate asynchronous return to reset values; the frame is lost.

## Configuration
- `FFT8_SEQ_NATURAL_ORDER_EN` defined: EMIT beat j outputs slot j; `m_bin`=j, giving natural order 0..7.
- Undefined: EMIT outputs capture order; `m_bin` sequence is 0,4,1,5,2,6,3,7. The output buffer indexing logic for natural order is not compiled.

## Structure
- `fft8_pkg`: state enum (`FILL`, `FEED`, `WAIT`, `CAPTURE`, `EMIT`), `FFT_N`=8, `FFT_PAIRS`=4, bin index typedef (3-bit).
- Sub-module `fft8_seq_buf`: 8-entry × 2W register file with one write port and one read port, no reset on the data array. It is instantiated twice, as the input and output buffers. CAPTURE uses two write ports on the output buffer, exposed via a dual-write parameter.

## Test plan
- Reset, then samples re=0..7, im=0, with `s_valid` held 1:
  - `p_en` is high exactly 8 consecutive cycles with `p_xr`=0..7.
  - A processor model returning pair k = (10k, 10k+40) yields 8 beats, bins as configured, `m_last` only on beat 8.
- Input stalls: `s_valid` toggles 1/0 while loading 8 samples → `p_en` still 8 contiguous cycles, values 0..7 in order.
- Output backpressure: `m_ready` low for 3 cycles at beat 2 → `m_re`/`m_bin` held, no beat lost or duplicated, 8 beats total.
- `flush` asserted during FEED k=3 → next cycle `p_en`=0 and `s_ready`=1. A fresh frame of 8 samples then completes normally.
- `rst_n` pulsed low during EMIT beat 5 → all outputs immediately at reset values; the next frame is correct.
- Back-to-back frames with `m_ready`=1 → second frame's first `p_en` occurs 27+LAT cycles after the first frame's first `p_en` when input is pre-queued.
